// File: rtl/retospect_neuro_pkg.sv
// -----------------------------------------------------------------------------
// retospect_neuro_pkg
//   Shared definitions for the retospect neuron fabric: the neuron state
//   encoding, the default cell geometry and a helper that derives the length
//   of one configuration frame from the field widths.
//   No ports (package).
// -----------------------------------------------------------------------------
package retospect_neuro_pkg;

    // Dynamic state of a neuron. The firing event lives in the axon register,
    // so only integration and the refractory dead time need encoding.
    typedef enum logic [0:0] {
        INTEG  = 1'b0,
        REFRAC = 1'b1
    } state_e;

    // Default cell geometry.
    localparam int DEF_NUM_DEND    = 4;
    localparam int DEF_W_BITS      = 4;
    localparam int DEF_POT_BITS    = 5;
    localparam int DEF_CLKSEL_BITS = 3;
    localparam int DEF_REFRAC_BITS = 3;

    // Number of bits in one configuration frame:
    // NUM_DEND weights, threshold, decay-clock select and refractory length.
    function automatic int cfg_len(
        input int num_dend,
        input int w_bits,
        input int pot_bits,
        input int clksel_bits,
        input int refrac_bits
    );
        return num_dend * w_bits + pot_bits + clksel_bits + refrac_bits;
    endfunction

endpackage : retospect_neuro_pkg

// File: rtl/retospect_lif_neuron_sat_accum.sv
// -----------------------------------------------------------------------------
// retospect_sat_accum
//   Purely combinational datapath of the neuron: optional leak (halving) of
//   the membrane potential, addition of every signed dendrite weight whose
//   dendrite is active, and a clamp of the result into the unsigned
//   potential range [0, 2**POT_BITS-1].
// Ports
//   potential_i  in  POT_BITS            current membrane potential (unsigned)
//   weights_i    in  NUM_DEND*W_BITS     weight i at [i*W_BITS +: W_BITS], two's complement
//   dendrite_i   in  NUM_DEND            active dendrites this cycle
//   leak_i       in  1                   1 = halve the potential before integrating
//   sat_sum_o    out POT_BITS            clamped new potential candidate
// -----------------------------------------------------------------------------
module retospect_sat_accum
    import retospect_neuro_pkg::*;
#(
    parameter int NUM_DEND = DEF_NUM_DEND,
    parameter int W_BITS   = DEF_W_BITS,
    parameter int POT_BITS = DEF_POT_BITS
) (
    input  logic [POT_BITS-1:0]        potential_i,
    input  logic [NUM_DEND*W_BITS-1:0] weights_i,
    input  logic [NUM_DEND-1:0]        dendrite_i,
    input  logic                       leak_i,
    output logic [POT_BITS-1:0]        sat_sum_o
);

    // Two guard bits above the potential+weight width are enough to hold the
    // largest possible positive and negative totals without wrapping.
    localparam int SUM_BITS = POT_BITS + W_BITS + 2;

    localparam logic [SUM_BITS-1:0] POT_MAX_EXT =
        {{(SUM_BITS-POT_BITS){1'b0}}, {POT_BITS{1'b1}}};

    logic [POT_BITS-1:0] p0_s;
    logic [SUM_BITS-1:0] sum_s;

    // Leak select, then accumulate all active sign-extended weights at once.
    always_comb begin
        p0_s  = leak_i ? (potential_i >> 1) : potential_i;
        sum_s = {{(SUM_BITS-POT_BITS){1'b0}}, p0_s};
        for (int i = 0; i < NUM_DEND; i++) begin
            if (dendrite_i[i]) begin
                sum_s = sum_s + {{(SUM_BITS-W_BITS){weights_i[i*W_BITS+W_BITS-1]}},
                                 weights_i[i*W_BITS +: W_BITS]};
            end else begin
                sum_s = sum_s;
            end
        end
    end

    // Clamp: a set sign bit means the total went negative.
    always_comb begin
        if (sum_s[SUM_BITS-1]) begin
            sat_sum_o = {POT_BITS{1'b0}};
        end else if (sum_s > POT_MAX_EXT) begin
            sat_sum_o = {POT_BITS{1'b1}};
        end else begin
            sat_sum_o = sum_s[POT_BITS-1:0];
        end
    end

endmodule : retospect_sat_accum

// File: rtl/retospect_lif_neuron.sv
// -----------------------------------------------------------------------------
// retospect_lif_neuron
//   Leaky integrate-and-fire neuron cell for the neurochip array. Holds its
//   configuration (weights, threshold, decay-clock select, refractory length)
//   in a serial shift chain, integrates weighted dendrite spikes into a
//   saturating membrane potential, fires a registered one-cycle axon spike
//   when the threshold is reached and then sits out a programmable number of
//   refractory cycles.
// Ports
//   clk        in   1                 system clock, rising edge
//   rst_n      in   1                 asynchronous active-low reset (clears config too)
//   reset_nn   in   1                 synchronous network reset, config kept
//   config_en  in   1                 shift the config chain one bit
//   bs_in      in   1                 config chain serial input
//   bs_out     out  1                 config chain serial output (refrac[0])
//   clockbus   in   2**CLKSEL_BITS    decay strobes; [0] never, [1] always
//   dendrite   in   NUM_DEND          incoming spikes
//   axon       out  1                 registered spike output
// -----------------------------------------------------------------------------
module retospect_lif_neuron
    import retospect_neuro_pkg::*;
#(
    parameter int NUM_DEND    = DEF_NUM_DEND,
    parameter int W_BITS      = DEF_W_BITS,
    parameter int POT_BITS    = DEF_POT_BITS,
    parameter int CLKSEL_BITS = DEF_CLKSEL_BITS,
    parameter int REFRAC_BITS = DEF_REFRAC_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        reset_nn,
    input  logic                        config_en,
    input  logic                        bs_in,
    output logic                        bs_out,
    input  logic [(2**CLKSEL_BITS)-1:0] clockbus,
    input  logic [NUM_DEND-1:0]         dendrite,
    output logic                        axon
);

    localparam int CFG_LEN = cfg_len(NUM_DEND, W_BITS, POT_BITS, CLKSEL_BITS, REFRAC_BITS);

    // Frame layout, MSB first: w[0], w[1], ..., w[NUM_DEND-1], thresh, clksel, refrac.
    // The chain shifts right, so bs_in enters w[0]'s MSB and refrac[0] leaves on bs_out.
    localparam int CLKSEL_LSB = REFRAC_BITS;
    localparam int THRESH_LSB = REFRAC_BITS + CLKSEL_BITS;

    localparam logic [REFRAC_BITS-1:0] CNT_ZERO = {REFRAC_BITS{1'b0}};
    localparam logic [REFRAC_BITS-1:0] CNT_ONE  = {{(REFRAC_BITS-1){1'b0}}, 1'b1};
    localparam logic [POT_BITS-1:0]    POT_ZERO = {POT_BITS{1'b0}};

    logic [CFG_LEN-1:0]         cfg_q, cfg_d;
    logic [POT_BITS-1:0]        pot_q, pot_d;
    logic [REFRAC_BITS-1:0]     cnt_q, cnt_d;
    state_e                     state_q, state_d;
    logic                       axon_q, axon_d;

    logic [REFRAC_BITS-1:0]     refrac_s;
    logic [CLKSEL_BITS-1:0]     clksel_s;
    logic [POT_BITS-1:0]        thresh_s;
    logic [NUM_DEND*W_BITS-1:0] weights_s;
    logic                       leak_s;
    logic [POT_BITS-1:0]        sat_s;

    assign refrac_s = cfg_q[REFRAC_BITS-1:0];
    assign clksel_s = cfg_q[CLKSEL_LSB +: CLKSEL_BITS];
    assign thresh_s = cfg_q[THRESH_LSB +: POT_BITS];
    assign leak_s   = clockbus[clksel_s];
    assign bs_out   = cfg_q[0];
    assign axon     = axon_q;

    // Repack weights so that w[i] sits at [i*W_BITS] for the accumulator.
    always_comb begin
        weights_s = {(NUM_DEND*W_BITS){1'b0}};
        for (int i = 0; i < NUM_DEND; i++) begin
            weights_s[i*W_BITS +: W_BITS] = cfg_q[CFG_LEN-(i+1)*W_BITS +: W_BITS];
        end
    end

    retospect_sat_accum #(
        .NUM_DEND (NUM_DEND),
        .W_BITS   (W_BITS),
        .POT_BITS (POT_BITS)
    ) u_sat_accum (
        .potential_i (pot_q),
        .weights_i   (weights_s),
        .dendrite_i  (dendrite),
        .leak_i      (leak_s),
        .sat_sum_o   (sat_s)
    );

    // Config chain next value; a network reset takes priority and keeps it.
    always_comb begin
        cfg_d = cfg_q;
        if (reset_nn) begin
            cfg_d = cfg_q;
        end else if (config_en) begin
            cfg_d = {bs_in, cfg_q[CFG_LEN-1:1]};
        end else begin
            cfg_d = cfg_q;
        end
    end

    // Next-state logic for potential, refractory count, FSM and axon.
    always_comb begin
        state_d = state_q;
        pot_d   = pot_q;
        cnt_d   = cnt_q;
        axon_d  = 1'b0;
        if (reset_nn) begin
            state_d = INTEG;
            pot_d   = POT_ZERO;
            cnt_d   = CNT_ZERO;
        end else if (config_en) begin
            // Reconfiguration freezes all dynamic state; no spike may escape.
            state_d = state_q;
        end else begin
            case (state_q)
                INTEG: begin
                    if (sat_s >= thresh_s) begin
                        axon_d  = 1'b1;
                        pot_d   = POT_ZERO;
                        cnt_d   = refrac_s;
                        state_d = (refrac_s != CNT_ZERO) ? REFRAC : INTEG;
                    end else begin
                        pot_d   = sat_s;
                    end
                end
                REFRAC: begin
                    pot_d = POT_ZERO;
                    // Leaving on count==1 yields exactly refrac dead cycles;
                    // a zero count here is unreachable and is treated the same.
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = CNT_ZERO;
                        state_d = INTEG;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = INTEG;
                    pot_d   = POT_ZERO;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Configuration chain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= {CFG_LEN{1'b0}};
        end else begin
            cfg_q <= cfg_d;
        end
    end

    // Dynamic state registers: potential, refractory count, FSM state, axon.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INTEG;
            pot_q   <= POT_ZERO;
            cnt_q   <= CNT_ZERO;
            axon_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pot_q   <= pot_d;
            cnt_q   <= cnt_d;
            axon_q  <= axon_d;
        end
    end

endmodule : retospect_lif_neuron

// File: tb/tb_retospect_lif_neuron.sv
// -----------------------------------------------------------------------------
// tb_retospect_lif_neuron
//   Self-checking bench for retospect_lif_neuron at default parameters.
//   Expected values are pushed to a scoreboard queue when stimulus is driven
//   and popped when the corresponding DUT value is sampled (#1 after posedge).
// -----------------------------------------------------------------------------
module tb_retospect_lif_neuron;
    import retospect_neuro_pkg::*;

    localparam int CFG_LEN = 27;

    logic       clk;
    logic       rst_n;
    logic       reset_nn;
    logic       config_en;
    logic       bs_in;
    logic       bs_out;
    logic [7:0] clockbus;
    logic [3:0] dendrite;
    logic       axon;

    int checks;
    int errors;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];

    retospect_lif_neuron dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reset_nn  (reset_nn),
        .config_en (config_en),
        .bs_in     (bs_in),
        .bs_out    (bs_out),
        .clockbus  (clockbus),
        .dendrite  (dendrite),
        .axon      (axon)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Run-time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop_check(input int obs);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sb_q.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    function automatic logic [CFG_LEN-1:0] make_frame(
        input logic [3:0] w0, input logic [3:0] w1,
        input logic [3:0] w2, input logic [3:0] w3,
        input logic [4:0] th, input logic [2:0] cs, input logic [2:0] rf);
        return {w0, w1, w2, w3, th, cs, rf};
    endfunction

    // One run cycle: drive dendrites, expect axon and potential after the edge.
    task automatic step(input logic [3:0] d, input int exp_axon, input int exp_pot);
        dendrite = d;
        sb_push("axon", exp_axon);
        sb_push("pot", exp_pot);
        @(posedge clk);
        #1;
        sb_pop_check(int'(axon));
        sb_pop_check(int'(dut.pot_q));
        dendrite = 4'b0000;
    endtask

    // One config shift; the axon must stay low while shifting.
    task automatic shift_bit(input logic b);
        config_en = 1'b1;
        bs_in     = b;
        sb_push("cfg_axon", 0);
        @(posedge clk);
        #1;
        sb_pop_check(int'(axon));
    endtask

    task automatic load_cfg(input logic [CFG_LEN-1:0] f);
        for (int t = 0; t < CFG_LEN; t++) begin
            shift_bit(f[t]);
        end
        config_en = 1'b0;
        bs_in     = 1'b0;
    endtask

    task automatic nn_reset();
        reset_nn = 1'b1;
        @(posedge clk);
        #1;
        reset_nn = 1'b0;
    endtask

    logic [CFG_LEN-1:0] fa, fb, fw, fs, fl0, fl1, fr, ft;

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        reset_nn  = 1'b0;
        config_en = 1'b0;
        bs_in     = 1'b0;
        clockbus  = 8'b0000_0010;
        dendrite  = 4'b0000;

        fa  = 27'h2A3C1E7;
        fb  = 27'h15C3E18;
        fw  = make_frame(4'd3, 4'd3, 4'd3, 4'd3, 5'd9, 3'd0, 3'd0);
        fs  = make_frame(4'd7, 4'h8, 4'd0, 4'd0, 5'd31, 3'd0, 3'd0);
        fl0 = make_frame(4'd4, 4'd0, 4'd0, 4'd0, 5'd31, 3'd0, 3'd0);
        fl1 = make_frame(4'd4, 4'd0, 4'd0, 4'd0, 5'd31, 3'd1, 3'd0);
        fr  = make_frame(4'd2, 4'd0, 4'd0, 4'd0, 5'd2, 3'd0, 3'd3);
        ft  = make_frame(4'd0, 4'd0, 4'd0, 4'd0, 5'd0, 3'd0, 3'd1);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_axon", int'(axon), 0);
        chk("rst_bs_out", int'(bs_out), 0);
        chk("rst_pot", int'(dut.pot_q), 0);
        chk("rst_cfg", int'(dut.cfg_q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test 1: config chain load and replay.
        load_cfg(fa);
        chk("cfg_a", int'(dut.cfg_q), int'(fa));
        chk("thresh_a", int'(dut.thresh_s), int'(fa[10:6]));
        for (int t = 0; t < CFG_LEN; t++) begin
            sb_push("bs_replay", int'(fa[t]));
            sb_pop_check(int'(bs_out));
            shift_bit(fb[t]);
        end
        config_en = 1'b0;
        chk("cfg_b", int'(dut.cfg_q), int'(fb));

        // Test 2: integrate and fire.
        load_cfg(fw);
        nn_reset();
        step(4'b0001, 0, 3);
        step(4'b0001, 0, 6);
        step(4'b0001, 1, 0);
        step(4'b0000, 0, 0);

        // Test 3: sign, simultaneous dendrites and saturation.
        load_cfg(fs);
        nn_reset();
        step(4'b0011, 0, 0);
        step(4'b0001, 0, 7);
        step(4'b0011, 0, 6);
        nn_reset();
        step(4'b0001, 0, 7);
        step(4'b0001, 0, 14);
        step(4'b0001, 0, 21);
        step(4'b0001, 0, 28);
        step(4'b0001, 1, 0);

        // Test 4: leak select; reconfiguring holds the potential.
        load_cfg(fl0);
        nn_reset();
        step(4'b0001, 0, 4);
        step(4'b0001, 0, 8);
        step(4'b0001, 0, 12);
        step(4'b0000, 0, 12);
        step(4'b0000, 0, 12);
        load_cfg(fl1);
        step(4'b0000, 0, 6);
        step(4'b0000, 0, 3);
        step(4'b0000, 0, 1);
        step(4'b0000, 0, 0);

        // Test 5: refractory period, with a reconfiguration frozen mid-REFRAC.
        load_cfg(fr);
        nn_reset();
        step(4'b0001, 1, 0);
        step(4'b0001, 0, 0);
        load_cfg(fr);
        chk("cnt_frozen", int'(dut.cnt_q), 2);
        chk("state_frozen", int'(dut.state_q), int'(REFRAC));
        step(4'b0001, 0, 0);
        step(4'b0001, 0, 0);
        step(4'b0001, 1, 0);
        step(4'b0001, 0, 0);
        step(4'b0001, 0, 0);
        step(4'b0001, 0, 0);
        step(4'b0001, 1, 0);

        // Test 6a: reset_nn mid-REFRAC aborts to INTEG with config intact.
        step(4'b0001, 0, 0);
        nn_reset();
        chk("nn_state", int'(dut.state_q), int'(INTEG));
        chk("nn_axon", int'(axon), 0);
        chk("nn_pot", int'(dut.pot_q), 0);
        chk("nn_cfg", int'(dut.cfg_q), int'(fr));
        step(4'b0001, 1, 0);

        // Test 6b: async reset between edges while shifting.
        load_cfg(ft);
        nn_reset();
        step(4'b0000, 1, 0);
        chk("pre_bs_out", int'(bs_out), 1);
        config_en = 1'b1;
        bs_in     = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_axon", int'(axon), 0);
        chk("async_bs_out", int'(bs_out), 0);
        chk("async_cfg", int'(dut.cfg_q), 0);
        config_en = 1'b0;
        bs_in     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // Zeroed frame means thresh=0: fires every INTEG cycle.
        step(4'b0000, 1, 0);
        step(4'b0000, 1, 0);
        step(4'b0000, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_retospect_lif_neuron
